// File: rtl/tq1m_pkg.sv
// tq1m_pkg: shared types and constants for the tq1m DAC test bus.
//   DEF_DOUT_WIDTH : default data bus width (matches the ramp transmitter)
//   rx_state_t     : receiver checker states, for readable debug decoding
//   ST_*           : state encodings used by the checker FSM register
//   word_t         : one bus word at the default width
package tq1m_pkg;

  localparam int DEF_DOUT_WIDTH = 8;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  localparam logic [1:0] ST_SEED   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef logic [DEF_DOUT_WIDTH-1:0] word_t;

endpackage

// File: rtl/dac_rx_sync.sv
// dac_rx_sync: brings the asynchronous dac_clk_i / din pair into the clk
// domain and flags each falling edge of dac_clk_i.
//   clk, rst   : local clock, synchronous active-high reset
//   dac_clk_i  : received DAC clock (asynchronous)
//   din        : received data word, changes on the dac_clk_i rising edge
//   fall       : registered one-cycle strobe, a dac_clk_i fall was seen
//   word       : din as it was at the sampled fall (valid with fall)
// dac_clk_i and din pass through delay lines of identical depth, so the word
// at the end of the din line belongs to the same sample instant as the clock
// level at the end of the clock line. The fall is the mid-point of the data
// eye because din only moves on the rising edge.
module dac_rx_sync
  import tq1m_pkg::*;
#(
  parameter int DOUT_WIDTH  = DEF_DOUT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dac_clk_i,
  input  logic [DOUT_WIDTH-1:0] din,
  output logic                  fall,
  output logic [DOUT_WIDTH-1:0] word
);

  localparam int LAST = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [DOUT_WIDTH-1:0]  din_sync [SYNC_STAGES];
  logic                   clk_prev;
  logic                   fall_now;

  assign fall_now = clk_prev && !clk_sync[LAST];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Clearing the clock line to 0 means a dac_clk_i that is high at
      // release first has to be seen high before any fall can be reported.
      clk_sync <= '0;
      clk_prev <= 1'b0;
      fall     <= 1'b0;
      word     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        din_sync[i] <= '0;
      end
    end else begin
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], dac_clk_i};
      din_sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        din_sync[i] <= din_sync[i-1];
      end
      clk_prev <= clk_sync[LAST];
      fall     <= fall_now;
      if (fall_now) begin
        word <= din_sync[LAST];
      end
    end
  end

endmodule

// File: rtl/dac_rx_checker.sv
// dac_rx_checker: receive end of the tq1m DAC test bus. Recovers each word
// sent on dac_clk_i/din, checks that successive words form a +1 ramp
// (wrapping at 2**DOUT_WIDTH), and reports lock, errors and an error count.
//   clk, rst     : local clock, synchronous active-high reset
//   dac_clk_i    : received DAC clock, asynchronous to clk
//   din          : received data word, changes on the dac_clk_i rise
//   sample_valid : one-cycle strobe, sample_data holds a new word
//   sample_data  : last captured word
//   locked       : LOCK_COUNT consecutive good words seen, ramp tracked
//   err          : one-cycle strobe with sample_valid on a ramp mismatch
//   err_cnt      : saturating mismatch count
//   period_err   : one-cycle strobe with sample_valid, period out of range
//   state_dbg    : current FSM state (ST_SEED / ST_TRACK / ST_LOCKED)
// Build option: define DAC_RX_PERIOD_CHECK_EN to add the dac_clk period
// check; without it period_err is constant 0.
// Handshake: sample_valid is a pure strobe with no ready; err and period_err
// are only ever high in the same cycle as sample_valid.
module dac_rx_checker
  import tq1m_pkg::*;
#(
  parameter int DOUT_WIDTH  = DEF_DOUT_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 16,
  parameter int TIMEOUT     = 1024,
  parameter int EXP_PERIOD  = 8,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dac_clk_i,
  input  logic [DOUT_WIDTH-1:0] din,
  output logic                  sample_valid,
  output logic [DOUT_WIDTH-1:0] sample_data,
  output logic                  locked,
  output logic                  err,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic                  period_err,
  output logic [1:0]            state_dbg
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  if (SYNC_STAGES < 2 || LOCK_COUNT < 1 || TIMEOUT < 2 || EXP_PERIOD < 2) begin : g_bad_cfg
    $error("dac_rx_checker: illegal parameter set");
  end

  logic                  fall_s;
  logic [DOUT_WIDTH-1:0] word_s;

  dac_rx_sync #(
    .DOUT_WIDTH  (DOUT_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .dac_clk_i (dac_clk_i),
    .din       (din),
    .fall      (fall_s),
    .word      (word_s)
  );

  logic [1:0]            state, state_n;
  logic [DOUT_WIDTH-1:0] expected, exp_n;
  logic [MW-1:0]         match_cnt, match_n;
  logic [TW-1:0]         to_cnt;
  logic                  bad;
  logic                  per_bad;

  assign state_dbg = state;

  // Next-state logic. Captured words drive the FSM; the timeout only acts
  // in a cycle without a fall, so a fall coinciding with expiry wins.
  always_comb begin
    state_n = state;
    exp_n   = expected;
    match_n = match_cnt;
    bad     = 1'b0;
    if (fall_s) begin
      // Whatever the outcome, the next expected word follows this one.
      exp_n = word_s + DOUT_WIDTH'(1);
      case (state)
        ST_SEED: begin
          match_n = '0;
          state_n = ST_TRACK;
        end
        ST_TRACK: begin
          if (word_s == expected) begin
            match_n = match_cnt + MW'(1);
            if (match_n == MW'(LOCK_COUNT)) begin
              state_n = ST_LOCKED;
            end
          end else begin
            bad     = 1'b1;
            match_n = '0;
          end
        end
        ST_LOCKED: begin
          if (word_s != expected) begin
            bad     = 1'b1;
            match_n = '0;
            state_n = ST_TRACK;
          end
        end
        default: begin
          match_n = '0;
          state_n = ST_SEED;
        end
      endcase
    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
      match_n = '0;
      state_n = ST_SEED;
    end
  end

`ifdef DAC_RX_PERIOD_CHECK_EN
  // per_cnt holds the number of clk cycles since the previous fall strobe
  // when the next one arrives. It saturates well above the tolerance band.
  localparam int PW = $clog2(EXP_PERIOD + 3);
  logic [PW-1:0] per_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (fall_s) begin
      per_cnt <= PW'(1);
    end else if (per_cnt != '1) begin
      per_cnt <= per_cnt + PW'(1);
    end
  end

  // The interval ending at a seed word may span idle time, so it is only
  // judged once the FSM is tracking.
  assign per_bad = fall_s && (state != ST_SEED) &&
                   ((int'(per_cnt) > EXP_PERIOD + 1) ||
                    (int'(per_cnt) + 1 < EXP_PERIOD));
`else
  assign per_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_SEED;
      expected     <= '0;
      match_cnt    <= '0;
      to_cnt       <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      locked       <= 1'b0;
      err          <= 1'b0;
      err_cnt      <= '0;
      period_err   <= 1'b0;
    end else begin
      state     <= state_n;
      expected  <= exp_n;
      match_cnt <= match_n;
      if (fall_s) begin
        to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT)) begin
        to_cnt <= to_cnt + TW'(1);
      end
      sample_valid <= fall_s;
      if (fall_s) begin
        sample_data <= word_s;
      end
      err        <= bad;
      period_err <= per_bad;
      if (bad && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
      // Registered from the next state so it moves in the same cycle as err.
      locked <= (state_n == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_dac_rx_checker.sv
`timescale 1ns/1ps
module tb_dac_rx_checker;
  import tq1m_pkg::*;

  // A narrow error counter lets saturation be reached in a few hundred words.
  localparam int CW   = 8;
  localparam int LOCK = 16;
  localparam int EW   = 8 + 1 + 1 + CW + 1;

  logic          clk;
  logic          rst;
  logic          dac_clk_i;
  word_t         din;
  logic          sample_valid;
  word_t         sample_data;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_cnt;
  logic          period_err;
  logic [1:0]    state_dbg;

  dac_rx_checker #(
    .DOUT_WIDTH  (8),
    .SYNC_STAGES (2),
    .LOCK_COUNT  (LOCK),
    .TIMEOUT     (1024),
    .EXP_PERIOD  (8),
    .ERR_CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dac_clk_i    (dac_clk_i),
    .din          (din),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .locked       (locked),
    .err          (err),
    .err_cnt      (err_cnt),
    .period_err   (period_err),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  int cyc;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int total;
  int bad;
  int perr_seen;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Ramp rule in plain terms: a word is good when it is the previous word
  // plus one (mod 256); lock means at least LOCK good words in a row since
  // the seed or the last bad word.
  logic  m_have;
  word_t m_prev;
  int    m_run;
  int    m_errs;
  int    last_fall_cyc;

  task automatic model_word(input word_t w);
    logic e, p, lk;
    int   iv;
    logic [CW-1:0] c;
    iv = cyc - last_fall_cyc;
    last_fall_cyc = cyc;
    e = 1'b0;
    p = 1'b0;
    if (!m_have) begin
      m_have = 1'b1;
      m_run  = 0;
    end else begin
      if (w == word_t'(int'(m_prev) + 1)) m_run++;
      else begin
        e = 1'b1;
        m_run = 0;
        m_errs++;
      end
`ifdef DAC_RX_PERIOD_CHECK_EN
      p = (iv > 9) || (iv < 7);
`endif
    end
    m_prev = w;
    lk = (m_run >= LOCK);
    c  = (m_errs > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(m_errs);
    exp_q.push_back({w, e, lk, c, p});
  endtask

  task automatic model_restart(input logic clear_errs);
    m_have = 1'b0;
    m_run  = 0;
    if (clear_errs) m_errs = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", 64'(sample_data), 64'hDEAD);
        end else begin
          chk("sample", 64'({sample_data, err, locked, err_cnt, period_err}),
              64'(exp_q.pop_front()));
        end
      end else if (err || period_err) begin
        chk("strobe_without_valid", 64'({err, period_err}), 64'd0);
      end
      if (period_err) perr_seen++;
    end
  end

  // ---------------- driver ----------------
  int tx_phase;

  task automatic tx_word(input word_t w, input int hi, input int lo);
    @(posedge clk);
    #(tx_phase);
    din = w;
    dac_clk_i = 1'b1;
    repeat (hi) @(posedge clk);
    #(tx_phase);
    dac_clk_i = 1'b0;
    model_word(w);
    repeat (lo - 1) @(posedge clk);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_restart(1'b1);
    @(negedge clk);
    chk("rst_sv", 64'(sample_valid), 64'd0);
    chk("rst_data", 64'(sample_data), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_errcnt", 64'(err_cnt), 64'd0);
    chk("rst_perr", 64'(period_err), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    word_t first;
    int    n;
    logic  exp_locked;
    int    exp_errs;
  } vec_t;

  vec_t vt[7];

  initial begin
    word_t w;
    int    sv_cnt;
    int    errs_before;
    int    perr_before;

    vt[0] = '{8'h00, 16,    1'b0, 0};  // seed + 15 good: not yet locked
    vt[1] = '{8'h10, 1,     1'b1, 0};  // 17th word locks
    vt[2] = '{8'h11, 'h12F, 1'b1, 0};  // through the FF->00 wrap, ends 0x3F
    vt[3] = '{8'h42, 1,     1'b0, 1};  // 0x42 where 0x40 is due
    vt[4] = '{8'h43, 15,    1'b0, 1};
    vt[5] = '{8'h52, 1,     1'b1, 1};  // 16th good word after the error
    vt[6] = '{8'h53, 20,    1'b1, 1};

    total = 0; bad = 0; perr_seen = 0; cyc = 0; last_fall_cyc = 0;
    m_errs = 0; m_prev = '0;
    model_restart(1'b1);
    rst = 1'b1; dac_clk_i = 1'b0; din = '0;
    tx_phase = $urandom_range(1, 9);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("init_sv", 64'(sample_valid), 64'd0);
    chk("init_locked", 64'(locked), 64'd0);
    chk("init_err", 64'(err), 64'd0);
    chk("init_errcnt", 64'(err_cnt), 64'd0);
    chk("init_perr", 64'(period_err), 64'd0);
    chk("init_state", 64'(state_dbg), 64'(ST_SEED));
    @(posedge clk);
    #1 rst = 1'b0;

    // Clean ramp, injected error and relock.
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < vt[r].n; k++) begin
        tx_word(word_t'(int'(vt[r].first) + k), 4, 4);
      end
      settle();
      chk($sformatf("row%0d_locked", r), 64'(locked), 64'(vt[r].exp_locked));
      chk($sformatf("row%0d_errcnt", r), 64'(err_cnt), 64'(vt[r].exp_errs));
    end

    // dac_clk stops: lock is held until the timeout, then drops silently.
    repeat (1010) @(posedge clk);
    @(negedge clk);
    chk("before_timeout_locked", 64'(locked), 64'd1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("timeout_locked", 64'(locked), 64'd0);
    chk("timeout_state", 64'(state_dbg), 64'(ST_SEED));
    chk("timeout_errcnt", 64'(err_cnt), 64'd1);
    model_restart(1'b0);
    tx_phase = $urandom_range(1, 9);
    for (int k = 0; k < 17; k++) tx_word(word_t'(8'h80 + k), 4, 4);
    settle();
    chk("relock_after_timeout", 64'(locked), 64'd1);

    // Reset while locked, in the low phase: no sample until the next fall.
    pulse_rst();
    sv_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (sample_valid) sv_cnt++;
    end
    chk("no_stale_sample", 64'(sv_cnt), 64'd0);
    for (int k = 0; k < 17; k++) tx_word(word_t'(8'hF8 + k), 4, 4);
    settle();
    chk("relock_after_rst", 64'(locked), 64'd1);
    chk("errcnt_after_rst", 64'(err_cnt), 64'd0);

    // Random words and phase lengths against the model.
    w = 8'h00;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) w = word_t'($urandom);
      else w = word_t'(int'(w) + 1);
      tx_word(w, $urandom_range(4, 6), $urandom_range(4, 6));
    end
    settle();

`ifdef DAC_RX_PERIOD_CHECK_EN
    for (int k = 0; k < 20; k++) tx_word(word_t'(8'h10 + k), 4, 4);
    errs_before = m_errs;
    perr_before = perr_seen;
    tx_word(8'h24, 7, 4);   // 4 + 7 = 11 clk interval
    tx_word(8'h25, 4, 4);
    tx_word(8'h26, 5, 4);   // 4 + 5 = 9 clk interval, inside tolerance
    settle();
    chk("stretch_perr_count", 64'(perr_seen - perr_before), 64'd1);
    chk("stretch_locked", 64'(locked), 64'd1);
    chk("stretch_errcnt", 64'(err_cnt), 64'(errs_before));
`else
    chk("perr_never", 64'(perr_seen), 64'd0);
`endif

    // Constant word: every capture after the seed is a mismatch.
    pulse_rst();
    for (int k = 0; k < 300; k++) tx_word(8'h55, 4, 4);
    settle();
    chk("sat_errcnt", 64'(err_cnt), 64'hFF);
    chk("sat_locked", 64'(locked), 64'd0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
